// File: rtl/alu_defs.sv
// alu_defs: op, state and status-flag encodings shared by the sequential ALU
package alu_defs;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;
    typedef enum logic {S_IDLE = 1'b0, S_MUL_RUN = 1'b1} state_t;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;
    function automatic logic [3:0] mk_flags(input logic z, input logic n, input logic v, input logic c);
        mk_flags = '0;
        mk_flags[FLAG_Z] = z;
        mk_flags[FLAG_N] = n;
        mk_flags[FLAG_V] = v;
        mk_flags[FLAG_C] = c;
    endfunction
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: unsigned shift-add multiplier, one multiplier bit per step
module mul_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0]   mplier;
    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= product;
        end
    end
    assign product = acc + (mplier[0] ? mcand : '0);
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with status flags and a start/busy/done multi-cycle multiplier
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             busy,
    output logic             done
);
    import alu_defs::*;
    state_t               state;
    logic [SHW-1:0]       cnt;
    logic [3:0]           st;
    logic [WIDTH:0]       add_s, sub_s;
    logic [2*WIDTH-1:0]   shl, prod;
    logic [WIDTH-1:0]     res;
    logic                 v, c;
    logic                 take_mul;
    assign add_s    = {1'b0, Ain} + {1'b0, Bin};
    assign sub_s    = {1'b0, Ain} + {1'b0, ~Bin} + {{WIDTH{1'b0}}, 1'b1};
    // bit WIDTH of the widened shift is the last bit pushed out, and is 0 for shamt=0
    assign shl      = {{WIDTH{1'b0}}, Ain} << Bin[SHW-1:0];
    assign take_mul = state == S_IDLE && start && ALUop == OP_MUL;
    always_comb begin
        res = add_s[WIDTH-1:0];
        c   = add_s[WIDTH];
        v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (add_s[WIDTH-1] != Ain[WIDTH-1]);
        case (ALUop)
            OP_SUB: begin
                res = sub_s[WIDTH-1:0];
                c   = sub_s[WIDTH];
                v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (sub_s[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND: {res, v, c} = {Ain & Bin, 2'b00};
            OP_NOT: {res, v, c} = {~Bin, 2'b00};
            OP_OR:  {res, v, c} = {Ain | Bin, 2'b00};
            OP_XOR: {res, v, c} = {Ain ^ Bin, 2'b00};
            OP_LSL: {res, v, c} = {shl[WIDTH-1:0], 1'b0, shl[WIDTH]};
            default: ;
        endcase
    end
    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .load   (take_mul),
        .step   (state == S_MUL_RUN),
        .a      (Ain),
        .b      (Bin),
        .product(prod)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            out   <= '0;
            st    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (take_mul) begin
                    state <= S_MUL_RUN;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end else if (start) begin
                    out  <= res;
                    st   <= mk_flags(res == '0, res[WIDTH-1], v, c);
                    done <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == SHW'(WIDTH - 1)) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    out   <= prod[WIDTH-1:0];
                    st    <= mk_flags(prod[WIDTH-1:0] == '0, prod[WIDTH-1], |prod[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
        end
    end
    assign Z = st[FLAG_Z];
    assign N = st[FLAG_N];
    assign V = st[FLAG_V];
    assign C = st[FLAG_C];
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  ALUop;
    logic [15:0] Ain, Bin, out;
    logic        Z, N, V, C, busy, done;
    int          checks = 0, failures = 0;
    int          n, extra;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ALUop(ALUop),
        .Ain(Ain), .Bin(Bin), .out(out), .Z(Z), .N(N), .V(V), .C(C),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        ALUop = op;
        Ain   = a;
        Bin   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] eo, input logic [3:0] ef);
        chk({tag, " out"}, 32'(out), 32'(eo));
        chk({tag, " zvnc"}, 32'({Z, N, V, C}), 32'(ef));
        chk({tag, " done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_mul(input string tag);
        n = 0;
        extra = 0;
        while (busy && n < 40) begin
            if (done) extra++;
            @(negedge clk);
            n++;
        end
        chk({tag, " busy cycles"}, 32'(n), 32'd16);
        chk({tag, " done during busy"}, 32'(extra), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ALUop   = 3'b000;
        Ain     = '0;
        Bin     = '0;
        repeat (2) @(negedge clk);
        chk("reset out", 32'(out), 32'd0);
        chk("reset flags", 32'({Z, N, V, C}), 32'd0);
        chk("reset busy/done", 32'({busy, done}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 16'h7FFF, 16'h0001);
        chk_res("add ovf", 16'h8000, 4'b0110);
        chk("add busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done pulse", 32'(done), 32'd0);
        chk("out hold", 32'(out), 32'h8000);

        issue(3'b000, 16'hFFFF, 16'h0001);
        chk_res("add carry", 16'h0000, 4'b1001);
        issue(3'b001, 16'h0005, 16'h0005);
        chk_res("sub zero", 16'h0000, 4'b1001);
        issue(3'b001, 16'h0000, 16'h0001);
        chk_res("sub borrow", 16'hFFFF, 4'b0100);
        issue(3'b001, 16'h8000, 16'h0001);
        chk_res("sub ovf", 16'h7FFF, 4'b0011);
        issue(3'b010, 16'hF0F0, 16'hFF00);
        chk_res("and", 16'hF000, 4'b0100);
        issue(3'b011, 16'h1234, 16'hFFFF);
        chk_res("not", 16'h0000, 4'b1000);
        issue(3'b100, 16'h1234, 16'h4321);
        chk_res("or", 16'h5335, 4'b0000);
        issue(3'b110, 16'h8001, 16'h0001);
        chk_res("lsl 1", 16'h0002, 4'b0001);
        issue(3'b110, 16'h8001, 16'h0000);
        chk_res("lsl 0", 16'h8001, 4'b0100);
        issue(3'b110, 16'h0003, 16'h000F);
        chk_res("lsl 15", 16'h8000, 4'b0101);

        issue(3'b111, 16'h0100, 16'h0100);
        chk("mul busy", 32'(busy), 32'd1);
        n = 0;
        extra = 0;
        while (busy && n < 40) begin
            if (n == 3) begin
                start = 1'b1;
                ALUop = 3'b000;
                Ain   = 16'h0001;
                Bin   = 16'h0001;
            end else start = 1'b0;
            if (done) extra++;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("mul busy cycles", 32'(n), 32'd16);
        chk("mul done during busy", 32'(extra), 32'd0);
        chk_res("mul 256x256", 16'h0000, 4'b1010);
        @(negedge clk);
        chk("mul ignored start done", 32'(done), 32'd0);
        chk("mul ignored start out", 32'(out), 32'h0000);

        start = 1'b1;
        ALUop = 3'b000;
        Ain   = 16'h0003;
        Bin   = 16'h0004;
        @(negedge clk);
        chk_res("b2b add", 16'h0007, 4'b0000);
        ALUop = 3'b101;
        Ain   = 16'h00FF;
        Bin   = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        chk_res("b2b xor", 16'h0FF0, 4'b0000);
        @(negedge clk);
        chk("b2b done end", 32'(done), 32'd0);

        issue(3'b111, 16'h0003, 16'h0005);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort busy/done", 32'({busy, done}), 32'd0);
        chk("abort out", 32'(out), 32'd0);
        chk("abort flags", 32'({Z, N, V, C}), 32'd0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort no done", 32'(extra), 32'd0);

        issue(3'b111, 16'h0003, 16'h0005);
        wait_mul("mul 3x5");
        chk_res("mul 3x5", 16'h000F, 4'b0000);
        issue(3'b111, 16'hFFFF, 16'hFFFF);
        wait_mul("mul max");
        chk_res("mul max", 16'h0001, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor of the datapath ALU. Adds wider op set, carry flag, a multi-cycle shift-add multiplier, and a start/busy/done handshake, so the controller FSM can issue single-cycle and multi-cycle ops through one interface. Status flags {Z,N,V,C} are held in a status register that updates only on completion. Sits between the register-file operand muxes and the writeback mux; flags feed branch-condition logic.

Parameters:
WIDTH, 16, operand/result width in bits (≥4)
SHW, $clog2(WIDTH), shift-amount field width taken from Bin[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
start  input  1  request; sampled on rising edge when busy=0
ALUop  input  3  operation select, captured with start
Ain  input  WIDTH  operand A, captured with start
Bin  input  WIDTH  operand B, captured with start
out  output  WIDTH  registered result
Z  output  1  result zero
N  output  1  result MSB
V  output  1  signed overflow (ADD/SUB), upper-half-nonzero (MUL)
C  output  1  carry / shifted-out bit
busy  output  1  multiplier in progress
done  output  1  one-cycle pulse: out and flags valid/updated

Behaviour:
- One clock; reset is synchronous and active-low: reset_n=0 at a rising edge forces out=0, Z=N=V=C=0, busy=0, done=0, FSM→IDLE. Overrides everything, including an in-flight MUL (aborted, no done).
- Ops: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 NOT B; 100 OR; 101 XOR; 110 LSL A by Bin[SHW-1:0]; 111 MUL unsigned, out = low WIDTH bits of product.
- FSM: IDLE, MUL_RUN. start sampled at edge k while IDLE:
  single-cycle op → out/flags/done=1 registered at edge k (visible cycle k+1), stay IDLE.
  MUL → capture operands, clear accumulator, busy=1 from edge k; WIDTH iterations (one multiplier bit per cycle); at edge k+WIDTH busy=0, done=1, out/flags written → IDLE.
- start while busy=1: ignored, no queuing, no effect on operands.
- start in the cycle done=1 (IDLE): accepted normally (back-to-back issue, throughput 1 op/cycle for single-cycle ops).
- done is high exactly one cycle per accepted op; low otherwise.
- out and flags hold their last values between completions.
- Flags at completion: Z = (out==0); N = out[WIDTH-1] for all ops.
  ADD: C = carry out of bit WIDTH-1; V = carry into MSB XOR carry out of MSB.
  SUB: computed as A + ~B + 1; C = carry out (1 = no borrow); V as ADD.
  AND/NOT/OR/XOR: V=0, C=0.
  LSL: C = last bit shifted out (A[WIDTH-shamt]), C=0 if shamt=0; V=0.
  MUL: V = (upper WIDTH bits of 2·WIDTH product ≠ 0); C=0.
- Undefined/X ALUop: treat as ADD.

Decomposition:
- Shared package alu_defs: localparam op encodings (OP_ADD..OP_MUL), FSM state encodings (S_IDLE, S_MUL_RUN), flag bit positions for the 4-bit status vector {Z,N,V,C}.
- One sub-module: mul_shift_add (WIDTH param; load, step inputs; holds multiplicand, multiplier, 2·WIDTH accumulator; outputs product). Top owns FSM, combinational op mux, status register, handshake.

Test Plan:
- WIDTH=16, ADD 0x7FFF+0x0001 → one cycle after start: out=0x8000, done=1, N=1, V=1, C=0, Z=0; busy stays 0.
- SUB 0x0005-0x0005 → out=0x0000, Z=1, C=1, V=0, N=0; then SUB 0x0000-0x0001 → out=0xFFFF, N=1, C=0, V=0.
- LSL A=0x8001, Bin=0x0001 → out=0x0002, C=1; LSL with Bin=0x0000 → out=0x8001, C=0, N=1.
- MUL 0x0100×0x0100 → busy high 16 cycles, done exactly at 17th cycle after start, out=0x0000, Z=1, V=1; second start (ADD 1+1) issued mid-busy is ignored (no extra done, out unchanged).
- Back-to-back: ADD 3+4, then XOR 0x00FF^0x0F0F on consecutive cycles → out=0x0007 then 0x0FF0, done high two consecutive cycles, flags update each.
- Start MUL 0x0003×0x0005, drive reset_n=0 at cycle 5 → next cycle busy=0, done=0, out=0, flags=0; no done afterward; new MUL 3×5 after reset → out=0x000F, V=0 after 16 busy cycles.
